// File: rtl/piso_pkg.sv
// piso_pkg: shared state type and width limit for the PISO serializer
package piso_pkg;
    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } piso_state_t;
    localparam int PISO_MIN_WIDTH = 2;
endpackage

// File: rtl/piso_bit_counter.sv
// piso_bit_counter: down-counter with load, decrement enable and current/next zero flags
module piso_bit_counter #(
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic             zero,
    output logic             next_zero
);
    logic [CNT_W-1:0] cnt_q, cnt_d;
    always_comb begin
        cnt_d     = load ? load_val : (dec && !zero) ? cnt_q - CNT_W'(1) : cnt_q;
        zero      = cnt_q == '0;
        next_zero = cnt_d == '0;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end
endmodule

// File: rtl/piso_serializer.sv
// piso_serializer: valid/ready parallel-in serial-out shifter with per-word bit order and last marker
module piso_serializer
    import piso_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] load_data,
    input  logic             load_lsb_first,
    input  logic             load_valid,
    output logic             load_ready,
    output logic             ser_out,
    output logic             ser_valid,
    input  logic             ser_ready,
    output logic             ser_last,
    output logic             busy
);
    if (WIDTH < PISO_MIN_WIDTH) begin : g_width_check
        $error("piso_serializer: WIDTH must be at least %0d", PISO_MIN_WIDTH);
    end
    piso_state_t      state_q, state_d;
    logic [WIDTH-1:0] sreg_q, sreg_d;
    logic             lsb_q, lsb_d;
    logic             ser_out_q, ser_out_d;
    logic             ser_valid_q, ser_valid_d;
    logic             ser_last_q, ser_last_d;
    logic             load_fire, beat, cnt_zero, cnt_next_zero;
    piso_bit_counter #(.CNT_W(CNT_W)) u_cnt (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (load_fire),
        .load_val  (CNT_W'(WIDTH - 1)),
        .dec       (beat),
        .zero      (cnt_zero),
        .next_zero (cnt_next_zero)
    );
    // Outputs are registered from next-state values so a load is visible the very next cycle.
    always_comb begin
        load_ready  = (state_q == IDLE) || (ser_last_q && ser_ready);
        load_fire   = load_valid && load_ready;
        beat        = ser_valid_q && ser_ready;
        sreg_d      = load_fire ? load_data
                    : beat ? (lsb_q ? {1'b0, sreg_q[WIDTH-1:1]} : {sreg_q[WIDTH-2:0], 1'b0})
                    : sreg_q;
        lsb_d       = load_fire ? load_lsb_first : lsb_q;
        state_d     = load_fire ? SHIFT : (beat && cnt_zero) ? IDLE : state_q;
        ser_out_d   = lsb_d ? sreg_d[0] : sreg_d[WIDTH-1];
        ser_valid_d = state_d == SHIFT;
        ser_last_d  = (state_d == SHIFT) && cnt_next_zero;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            sreg_q      <= '0;
            lsb_q       <= 1'b0;
            ser_out_q   <= 1'b0;
            ser_valid_q <= 1'b0;
            ser_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            sreg_q      <= sreg_d;
            lsb_q       <= lsb_d;
            ser_out_q   <= ser_out_d;
            ser_valid_q <= ser_valid_d;
            ser_last_q  <= ser_last_d;
        end
    end
    assign ser_out   = ser_out_q;
    assign ser_valid = ser_valid_q;
    assign ser_last  = ser_last_q;
    assign busy      = ser_valid_q;
endmodule

// File: doc/piso_serializer.md
# piso_serializer

Parametrised parallel-in/serial-out shift register with a valid/ready load port, a valid/ready serial port with backpressure, a per-word selectable bit order, and an end-of-word marker. It replaces fixed 4-bit PISO chains wherever a datapath word has to leave the block one bit per clock, such as a serial link transmitter or a bit-serial arithmetic feed. It supports back-to-back words with no idle cycle between them.

## Interface
- `WIDTH`, default 8: word width in bits; must be at least 2.
- `CNT_W`, default `$clog2(WIDTH)`: bit-counter width; derived, not overridden.
- `clk` in, 1: single clock; all state updates on the rising edge.
- `rst_n` in, 1: asynchronous active-low reset; deassertion is synchronised externally.
- `load_data` in, WIDTH: parallel word to serialise.
- `load_lsb_first` in, 1: bit order for this word (1 = bit 0 first, 0 = bit WIDTH-1 first); sampled only on load.
- `load_valid` in, 1: upstream has a word.
- `load_ready` out, 1: block accepts a word this cycle; combinational.
- `ser_out` out, 1: current serial bit; registered.
- `ser_valid` out, 1: `ser_out` is valid; registered.
- `ser_ready` in, 1: downstream consumes the bit this cycle.
- `ser_last` out, 1: the current bit is the final bit of the word; registered.
- `busy` out, 1: a word is in flight; registered; equals `ser_valid`.

## Operation
- Two-state FSM, IDLE and SHIFT.
- Load fires when `load_valid && load_ready`. On a fire:
  - The shift register takes `load_data`.
  - The order flag takes `load_lsb_first`.
  - The counter is set to WIDTH-1.
  - The state becomes SHIFT.
- A beat fires when `ser_valid && ser_ready`. On a beat the register shifts by one, toward the LSB when LSB-first, otherwise toward the MSB, and the counter decrements.
- `ser_out` presents bit 0 of the register when LSB-first, otherwise bit WIDTH-1.
- `ser_last` = SHIFT and counter == 0.
- `load_ready` = IDLE, or (SHIFT and `ser_last` and `ser_ready`).
- The final beat with a simultaneous load reloads the register and stays in SHIFT, with no bubble cycle.
- The final beat without a load goes to IDLE, with `ser_valid` = 0.
- In SHIFT with `ser_ready` = 0, all state holds, so `ser_out`, `ser_valid` and `ser_last` are stable until consumed.
- In SHIFT, `load_valid` is ignored except on the final beat. `load_data` is not captured and no error is raised.
- Vacated register bits fill with 0. This is never observable on `ser_out` within a word.
- Reset values: IDLE, register 0, counter 0, `ser_out` 0, `ser_valid` 0, `ser_last` 0, `busy` 0. While `rst_n` is low, `load_ready` is 1 by the formula above, but loads are blocked by the reset.
- Reset mid-word discards the word. No partial word is resumed.

## Timing
- Load at edge N: first bit valid from cycle N+1.
- With `ser_ready` held high: exactly WIDTH valid cycles, N+1 through N+WIDTH, with `ser_last` in cycle N+WIDTH.
- Throughput: one word per WIDTH cycles when a load coincides with every final beat.
- `load_ready` depends combinationally on `ser_ready`, a single AND path. No other combinational input-to-output path exists.
- Each stalled cycle adds exactly one cycle of latency.

## Structure
- Package `piso_pkg` holds:
  - the state typedef `piso_state_t` with IDLE and SHIFT;
  - the helper constant `PISO_MIN_WIDTH = 2`.
- `piso_serializer` holds an elaboration-time assertion `WIDTH >= PISO_MIN_WIDTH`.
- One sub-module, `piso_bit_counter`, a down-counter with load, decrement enable and a zero flag, parametrised by `CNT_W`.
- The shift register and FSM stay in the top module.

## Test plan
- MSB-first: WIDTH=8, load 0xB4 with `load_lsb_first`=0 and `ser_ready`=1. Require bits 1,0,1,1,0,1,0,0 in cycles N+1 through N+8, with `ser_last` only at N+8 and `ser_valid` low at N+9.
- LSB-first: load 0xB4 with `load_lsb_first`=1. Require bits 0,0,1,0,1,1,0,1, then IDLE, with `load_ready`=1 in cycle N+9.
- Backpressure: load 0xB4 MSB-first and drop `ser_ready` for 3 cycles after the 2nd bit. Require `ser_out`=1 and `ser_valid`=1 held through the stall, then the remaining bits 1,1,0,1,0,0 with total latency WIDTH+3.
- Back-to-back: hold `load_valid` high with 0xB4 then 0x0F, both MSB-first. Require 0x0F captured on the final beat of 0xB4, with 16 contiguous valid cycles reading 10110100 then 00001111. Require `load_data` changes mid-word to be ignored.
- Reset mid-word: pulse `rst_n` low, asynchronously, after 3 bits. Require `ser_valid`, `ser_out`, `ser_last` and `busy` to be 0 immediately. After release, a fresh load of 0xFF produces exactly 8 ones.
- WIDTH=2 instance: load 0b10 LSB-first. Require bits 0 then 1, with `ser_last` on the second bit.
